// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a burst master and the axi_slave_mem target.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs of each of the five channels.
// Ports: AW, W, B, AR and R channel signals; the master modport drives
//        requests, write data and the B/R readies, and the slave modport
//        drives the readies plus the B/R responses.
interface axi_slave_mem_if #(
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 64,
   parameter int LSIZE  = 8,
   parameter int IDSIZE = 4
);
   logic [IDSIZE-1:0]  axi_awid;
   logic [ASIZE-1:0]   axi_awaddr;
   logic [LSIZE-1:0]   axi_awlen;
   logic [1:0]         axi_awburst;
   logic [2:0]         axi_awsize;
   logic               axi_awlock;
   logic [3:0]         axi_awcache;
   logic [2:0]         axi_awprot;
   logic [3:0]         axi_awqos;
   logic               axi_awvalid;
   logic               axi_awready;
   logic [DSIZE-1:0]   axi_wdata;
   logic [DSIZE/8-1:0] axi_wstrb;
   logic               axi_wlast;
   logic               axi_wvalid;
   logic               axi_wready;
   logic [IDSIZE-1:0]  axi_bid;
   logic [1:0]         axi_bresp;
   logic               axi_bvalid;
   logic               axi_bready;
   logic [IDSIZE-1:0]  axi_arid;
   logic [ASIZE-1:0]   axi_araddr;
   logic [LSIZE-1:0]   axi_arlen;
   logic [1:0]         axi_arburst;
   logic [2:0]         axi_arsize;
   logic               axi_arlock;
   logic [3:0]         axi_arcache;
   logic [2:0]         axi_arprot;
   logic [3:0]         axi_arqos;
   logic               axi_arvalid;
   logic               axi_arready;
   logic [IDSIZE-1:0]  axi_rid;
   logic [DSIZE-1:0]   axi_rdata;
   logic [1:0]         axi_rresp;
   logic               axi_rlast;
   logic               axi_rvalid;
   logic               axi_rready;

   modport slave (
      input  axi_awid, axi_awaddr, axi_awlen, axi_awburst, axi_awsize, axi_awlock,
             axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
             axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
             axi_arid, axi_araddr, axi_arlen, axi_arburst, axi_arsize, axi_arlock,
             axi_arcache, axi_arprot, axi_arqos, axi_arvalid, axi_rready,
      output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
             axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
   );

   modport master (
      output axi_awid, axi_awaddr, axi_awlen, axi_awburst, axi_awsize, axi_awlock,
             axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
             axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
             axi_arid, axi_araddr, axi_arlen, axi_arburst, axi_arsize, axi_arlock,
             axi_arcache, axi_arprot, axi_arqos, axi_arvalid, axi_rready,
      input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
             axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
   );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 slave with byte-strobed internal memory; FIXED/INCR/WRAP bursts, one outstanding txn per direction.
// Latency: AR handshake at edge N -> first R beat at N+1; a W beat is written on its handshake edge; B follows the wlast beat.
// Backpressure: R beats and B are held while rready/bready are low; optional macro AXI_SLAVE_BACKPRESSURE_EN adds LFSR gating of awready/wready/arready.
// Ports: axi_aclk, axi_resetn (async active-low), axi (axi_slave_mem_if.slave).
module axi_slave_mem #(
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 64,
   parameter int LSIZE  = 8,
   parameter int IDSIZE = 4,
   parameter int MEM_AW = 10
) (
   input  logic           axi_aclk,
   input  logic           axi_resetn,
   axi_slave_mem_if.slave axi
);
   localparam int BYTES = DSIZE/8;
   localparam int BOFF  = $clog2(BYTES);

   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
   localparam logic [1:0] BURST_FIXED = 2'b00, BURST_WRAP = 2'b10, BURST_RSVD = 2'b11;
   localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

   // Reserved burst type and WRAP with a length other than 2/4/8/16 beats.
   function automatic logic burst_bad(input logic [1:0] burst, input logic [LSIZE-1:0] len);
      burst_bad = (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && !((len == LSIZE'(1)) || (len == LSIZE'(3)) ||
                                              (len == LSIZE'(7)) || (len == LSIZE'(15))));
   endfunction

   // Address of the following beat; bad bursts step like INCR.
   function automatic logic [ASIZE-1:0] next_addr(input logic [ASIZE-1:0] addr,
                                                 input logic [LSIZE-1:0] len,
                                                 input logic [1:0]       burst);
      logic [ASIZE-1:0] inc;
      logic [ASIZE-1:0] mask;
      inc  = addr + ASIZE'(BYTES);
      mask = ((ASIZE'(len) + ASIZE'(1)) << BOFF) - ASIZE'(1);
      if (burst == BURST_FIXED)
         next_addr = addr;
      else if ((burst == BURST_WRAP) && !burst_bad(burst, len))
         next_addr = (addr & ~mask) | (inc & mask);
      else
         next_addr = inc;
   endfunction

   logic [DSIZE-1:0] mem [0:(2**MEM_AW)-1];

   // Ready gating: free-running LFSR when the backpressure option is built in.
   logic rdy_gate;
`ifdef AXI_SLAVE_BACKPRESSURE_EN
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) lfsr_q <= 16'hACE1;
      else             lfsr_q <= lfsr_d;
   end
   assign rdy_gate = (lfsr_q[1:0] != 2'b00);
`else
   assign rdy_gate = 1'b1;
`endif

   // ---------------- write channel ----------------
   logic [1:0]        w_state_q, w_state_d;
   logic [IDSIZE-1:0] w_id_q, w_id_d;
   logic [ASIZE-1:0]  w_addr_q, w_addr_d;
   logic [LSIZE-1:0]  w_len_q, w_len_d;
   logic [1:0]        w_burst_q, w_burst_d;
   logic [LSIZE-1:0]  w_beat_q, w_beat_d;
   logic              w_err_q, w_err_d;
   logic              w_over_q, w_over_d;   // beat len already taken; later beats are dropped
   logic              aw_hs, w_hs, b_hs, w_at_end, mem_we;

   assign axi.axi_awready = (w_state_q == W_IDLE) && rdy_gate;
   assign axi.axi_wready  = (w_state_q == W_DATA) && rdy_gate;
   assign axi.axi_bvalid  = (w_state_q == W_RESP);
   assign axi.axi_bid     = axi.axi_bvalid ? w_id_q : '0;
   assign axi.axi_bresp   = !axi.axi_bvalid ? RESP_OKAY : (w_err_q ? RESP_SLVERR : RESP_OKAY);

   assign aw_hs    = axi.axi_awvalid && axi.axi_awready;
   assign w_hs     = axi.axi_wvalid && axi.axi_wready;
   assign b_hs     = axi.axi_bvalid && axi.axi_bready;
   assign w_at_end = !w_over_q && (w_beat_q == w_len_q);
   assign mem_we   = w_hs && !w_over_q;

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_burst_d = w_burst_q;
      w_beat_d  = w_beat_q;
      w_err_d   = w_err_q;
      w_over_d  = w_over_q;
      case (w_state_q)
         W_IDLE: if (aw_hs) begin
            w_id_d    = axi.axi_awid;
            w_addr_d  = axi.axi_awaddr;
            w_len_d   = axi.axi_awlen;
            w_burst_d = axi.axi_awburst;
            w_beat_d  = '0;
            w_err_d   = burst_bad(axi.axi_awburst, axi.axi_awlen);
            w_over_d  = 1'b0;
            w_state_d = W_DATA;
         end
         W_DATA: if (w_hs) begin
            // wlast must coincide exactly with beat len
            if (axi.axi_wlast != w_at_end) w_err_d = 1'b1;
            if (w_at_end) begin
               w_over_d = 1'b1;
            end else if (!w_over_q) begin
               w_beat_d = w_beat_q + LSIZE'(1);
               w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
            end
            if (axi.axi_wlast) w_state_d = W_RESP;
         end
         W_RESP: if (b_hs) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_burst_q <= '0;
         w_beat_q  <= '0;
         w_err_q   <= 1'b0;
         w_over_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_burst_q <= w_burst_d;
         w_beat_q  <= w_beat_d;
         w_err_q   <= w_err_d;
         w_over_q  <= w_over_d;
      end
   end

   // Memory is never reset; contents survive axi_resetn.
   always_ff @(posedge axi_aclk) begin
      if (mem_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (axi.axi_wstrb[b])
               mem[w_addr_q[BOFF+MEM_AW-1:BOFF]][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   logic [0:0]        r_state_q, r_state_d;
   logic [IDSIZE-1:0] r_id_q, r_id_d;
   logic [ASIZE-1:0]  r_addr_q, r_addr_d, r_next;
   logic [LSIZE-1:0]  r_len_q, r_len_d;
   logic [1:0]        r_burst_q, r_burst_d;
   logic [LSIZE-1:0]  r_beat_q, r_beat_d;
   logic              r_err_q, r_err_d;
   logic [DSIZE-1:0]  r_data_q, r_data_d;
   logic              ar_hs, r_hs;

   assign axi.axi_arready = (r_state_q == R_IDLE) && rdy_gate;
   assign axi.axi_rvalid  = (r_state_q == R_DATA);
   assign axi.axi_rid     = axi.axi_rvalid ? r_id_q : '0;
   assign axi.axi_rresp   = (axi.axi_rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
   assign axi.axi_rlast   = axi.axi_rvalid && (r_beat_q == r_len_q);
   assign axi.axi_rdata   = r_data_q;

   assign ar_hs  = axi.axi_arvalid && axi.axi_arready;
   assign r_hs   = axi.axi_rvalid && axi.axi_rready;
   assign r_next = next_addr(r_addr_q, r_len_q, r_burst_q);

   // rdata is captured from mem on the same edge as any write, so a
   // colliding read sees the pre-write word.
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_burst_d = r_burst_q;
      r_beat_d  = r_beat_q;
      r_err_d   = r_err_q;
      r_data_d  = r_data_q;
      case (r_state_q)
         R_IDLE: if (ar_hs) begin
            r_id_d    = axi.axi_arid;
            r_addr_d  = axi.axi_araddr;
            r_len_d   = axi.axi_arlen;
            r_burst_d = axi.axi_arburst;
            r_beat_d  = '0;
            r_err_d   = burst_bad(axi.axi_arburst, axi.axi_arlen);
            r_data_d  = mem[axi.axi_araddr[BOFF+MEM_AW-1:BOFF]];
            r_state_d = R_DATA;
         end
         R_DATA: if (r_hs) begin
            if (axi.axi_rlast) begin
               r_state_d = R_IDLE;
            end else begin
               r_beat_d = r_beat_q + LSIZE'(1);
               r_addr_d = r_next;
               r_data_d = mem[r_next[BOFF+MEM_AW-1:BOFF]];
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_burst_q <= '0;
         r_beat_q  <= '0;
         r_err_q   <= 1'b0;
         r_data_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_burst_q <= r_burst_d;
         r_beat_q  <= r_beat_d;
         r_err_q   <= r_err_d;
         r_data_q  <= r_data_d;
      end
   end

   // Sideband fields are accepted but have no effect on this target.
   logic unused_sideband;
   assign unused_sideband = ^{axi.axi_awsize, axi.axi_awlock, axi.axi_awcache, axi.axi_awprot,
                              axi.axi_awqos, axi.axi_arsize, axi.axi_arlock, axi.axi_arcache,
                              axi.axi_arprot, axi.axi_arqos};
endmodule
